neureka_tcdm_responder: RTL and testbench

Memory-side responder for the NEUREKA TCDM master ports. It accepts MP independent 32-bit request ports and serves them from N_BANKS word-interleaved single-port banks. Per-bank round-robin arbitration resolves conflicts, and read responses follow one cycle after grant. It is used as the TCDM endpoint in the accelerator testbench and in standalone subsystem integration. Because it can withhold per-port grants, it exercises the all-ports-granted handshake of the wide accelerator master.

---
 rtl/neureka_tcdm_responder_pkg.sv | 19 +
 rtl/neureka_tcdm_responder_if.sv | 29 ++
 rtl/neureka_tcdm_rr_arbiter.sv | 47 ++++
 rtl/neureka_tcdm_responder.sv | 126 ++++++++++++
 tb/tb_neureka_tcdm_responder.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/neureka_tcdm_responder_pkg.sv
// Shared constants and payload types for the NEUREKA TCDM responder.
// Contents: default port/bank/depth sizing, bus widths, per-port response record.
package neureka_tcdm_responder_pkg;

  localparam int unsigned NEUREKA_TCDM_MP_DEFAULT    = 4;
  localparam int unsigned NEUREKA_TCDM_BANKS_DEFAULT = 8;
  localparam int unsigned NEUREKA_TCDM_DEPTH_DEFAULT = 256;

  localparam int unsigned TCDM_ADDR_W = 32;
  localparam int unsigned TCDM_DATA_W = 32;
  localparam int unsigned TCDM_BE_W   = TCDM_DATA_W / 8;

  // One response slot per request port.
  typedef struct packed {
    logic                   r_valid;
    logic [TCDM_DATA_W-1:0] r_data;
  } tcdm_resp_t;

endpackage

// File: rtl/neureka_tcdm_responder_if.sv
// TCDM request/response bundle for MP independent 32-bit ports.
// master: drives req/add/wen/be/data, receives gnt/r_data/r_valid.
// slave : the memory side (responder).
interface neureka_tcdm_responder_if
  import neureka_tcdm_responder_pkg::*;
#(
  parameter int unsigned MP = NEUREKA_TCDM_MP_DEFAULT
) ();

  logic [MP-1:0]                  req;
  logic [MP-1:0]                  gnt;
  logic [MP-1:0][TCDM_ADDR_W-1:0] add;
  logic [MP-1:0]                  wen;
  logic [MP-1:0][TCDM_BE_W-1:0]   be;
  logic [MP-1:0][TCDM_DATA_W-1:0] data;
  logic [MP-1:0][TCDM_DATA_W-1:0] r_data;
  logic [MP-1:0]                  r_valid;

  modport master (
    output req, add, wen, be, data,
    input  gnt, r_data, r_valid
  );

  modport slave (
    input  req, add, wen, be, data,
    output gnt, r_data, r_valid
  );

endinterface

// File: rtl/neureka_tcdm_rr_arbiter.sv
// Per-bank round-robin arbiter.
// Ports: clk_i, rst_ni (sync, active-low), i_req (MP candidate vector),
//        o_gnt (one-hot grant, combinational). The priority pointer
//        moves just past the winner and holds when nothing is granted.
module neureka_tcdm_rr_arbiter
  import neureka_tcdm_responder_pkg::*;
#(
  parameter int unsigned MP = NEUREKA_TCDM_MP_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [MP-1:0] i_req,
  output logic [MP-1:0] o_gnt
);

  localparam int unsigned PTR_W = (MP > 1) ? $clog2(MP) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  // Scan from r_ptr upward with wrap; first requester wins.
  always_comb begin
    o_gnt     = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    w_ptr_nxt = r_ptr;
    for (int unsigned k = 0; k < MP; k++) begin
      w_idx = PTR_W'((32'(r_ptr) + k) % MP);
      if (!w_found && i_req[w_idx]) begin
        w_found      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        w_ptr_nxt    = PTR_W'((32'(w_idx) + 32'd1) % MP);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/neureka_tcdm_responder.sv
// Memory-side TCDM responder: MP request ports served by N_BANKS
// word-interleaved single-port banks with per-bank round-robin arbitration.
// Ports: clk_i, rst_ni (sync, active-low), stall_i (per-port grant
//        suppression), tcdm (slave side of the TCDM bundle). Grants are
//        combinational; responses (reads and writes) arrive one cycle later.
module neureka_tcdm_responder
  import neureka_tcdm_responder_pkg::*;
#(
  parameter int unsigned MP      = NEUREKA_TCDM_MP_DEFAULT,
  parameter int unsigned N_BANKS = NEUREKA_TCDM_BANKS_DEFAULT,
  parameter int unsigned DEPTH   = NEUREKA_TCDM_DEPTH_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [MP-1:0]            stall_i,
  neureka_tcdm_responder_if.slave  tcdm
);

  localparam int unsigned BANK_W  = $clog2(N_BANKS);
  localparam int unsigned ROW_W   = $clog2(DEPTH);
  localparam int unsigned ROW_LSB = 2 + BANK_W;
  localparam int unsigned ADDR_HI = ROW_LSB + ROW_W;

  logic [MP-1:0][BANK_W-1:0]             w_bank;
  logic [MP-1:0][ROW_W-1:0]              w_row;
  logic [MP-1:0]                         w_unused_add;
  logic [N_BANKS-1:0][MP-1:0]            w_cand;
  logic [N_BANKS-1:0][MP-1:0]            w_bgnt;
  logic [MP-1:0]                         w_gnt;
  logic [N_BANKS-1:0]                    w_we;
  logic [N_BANKS-1:0][ROW_W-1:0]         w_wrow;
  logic [N_BANKS-1:0][TCDM_BE_W-1:0]     w_wbe;
  logic [N_BANKS-1:0][TCDM_DATA_W-1:0]   w_wdata;

  logic [TCDM_DATA_W-1:0] r_mem [N_BANKS][DEPTH];
  tcdm_resp_t [MP-1:0]    r_resp;

  // Word-interleaved decode; byte offset and bits above the array alias away.
  for (genvar p = 0; p < MP; p++) begin : g_dec
    assign w_bank[p]       = tcdm.add[p][2 +: BANK_W];
    assign w_row[p]        = tcdm.add[p][ROW_LSB +: ROW_W];
    assign w_unused_add[p] = ^{tcdm.add[p][1:0], tcdm.add[p][TCDM_ADDR_W-1:ADDR_HI]};
  end

  // Per-bank candidate vectors: stalled ports never compete.
  always_comb begin
    w_cand = '0;
    for (int unsigned b = 0; b < N_BANKS; b++) begin
      for (int unsigned p = 0; p < MP; p++) begin
        w_cand[b][p] = tcdm.req[p] & ~stall_i[p] & (w_bank[p] == BANK_W'(b));
      end
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    neureka_tcdm_rr_arbiter #(
      .MP (MP)
    ) u_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .i_req  (w_cand[b]),
      .o_gnt  (w_bgnt[b])
    );
  end

  // A port targets exactly one bank, so OR-ing bank grants stays one-hot per port.
  always_comb begin
    w_gnt = '0;
    for (int unsigned b = 0; b < N_BANKS; b++) begin
      w_gnt = w_gnt | w_bgnt[b];
    end
  end

  assign tcdm.gnt = w_gnt;

  // Route each bank's granted write (at most one) to its write port.
  always_comb begin
    w_we    = '0;
    w_wrow  = '0;
    w_wbe   = '0;
    w_wdata = '0;
    for (int unsigned b = 0; b < N_BANKS; b++) begin
      for (int unsigned p = 0; p < MP; p++) begin
        if (w_bgnt[b][p] && !tcdm.wen[p]) begin
          w_we[b]    = 1'b1;
          w_wrow[b]  = w_row[p];
          w_wbe[b]   = tcdm.be[p];
          w_wdata[b] = tcdm.data[p];
        end
      end
    end
  end

  // Bank storage: not reset, retained across reset; writes suppressed in reset.
  always_ff @(posedge clk_i) begin
    for (int unsigned b = 0; b < N_BANKS; b++) begin
      if (rst_ni && w_we[b]) begin
        for (int unsigned i = 0; i < TCDM_BE_W; i++) begin
          if (w_wbe[b][i]) begin
            r_mem[b][w_wrow[b]][8*i +: 8] <= w_wdata[b][8*i +: 8];
          end
        end
      end
    end
  end

  // One response per grant, one cycle later; reads capture pre-edge contents.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_resp <= '0;
    end else begin
      for (int unsigned p = 0; p < MP; p++) begin
        r_resp[p].r_valid <= w_gnt[p];
        r_resp[p].r_data  <= (w_gnt[p] && tcdm.wen[p]) ? r_mem[w_bank[p]][w_row[p]]
                                                       : TCDM_DATA_W'(0);
      end
    end
  end

  // Held reset masks a response that was registered just before it asserted.
  for (genvar p = 0; p < MP; p++) begin : g_resp
    assign tcdm.r_valid[p] = r_resp[p].r_valid & rst_ni;
    assign tcdm.r_data[p]  = rst_ni ? r_resp[p].r_data : TCDM_DATA_W'(0);
  end

endmodule

// File: tb/tb_neureka_tcdm_responder.sv
// Self-checking bench for neureka_tcdm_responder (MP=4, 8 banks, depth 256).
module tb_neureka_tcdm_responder;

  localparam int unsigned MP    = 4;
  localparam int unsigned NB    = 8;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned WORDS = NB * DEPTH;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [MP-1:0] stall;

  neureka_tcdm_responder_if #(.MP(MP)) bus ();

  neureka_tcdm_responder #(
    .MP      (MP),
    .N_BANKS (NB),
    .DEPTH   (DEPTH)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .stall_i (stall),
    .tcdm    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: flat word memory, per-bank priority pointer, pending responses.
  logic [31:0]   m_mem [WORDS];
  int            m_ptr [NB];
  logic [MP-1:0] m_rv = '0;
  logic [31:0]   m_rd [MP];

  logic [MP-1:0] obs_gnt, obs_rv;
  logic [31:0]   obs_rd [MP];

  typedef struct {
    logic [MP-1:0]       req;
    logic [MP-1:0]       stall;
    logic [MP-1:0][31:0] add;
    logic [MP-1:0]       exp_gnt;
  } vec_t;

  vec_t vecs [9];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % WORDS);
  endfunction

  // Per bank, first eligible port at or after the pointer (wrapping) wins.
  function automatic logic [MP-1:0] model_gnt();
    logic [MP-1:0] g;
    bit taken;
    g = '0;
    for (int b = 0; b < NB; b++) begin
      taken = 0;
      for (int k = 0; k < MP; k++) begin
        int p;
        p = (m_ptr[b] + k) % MP;
        if (!taken && bus.req[p] && !stall[p] && (word_of(bus.add[p]) % NB) == b) begin
          g[p]  = 1'b1;
          taken = 1;
        end
      end
    end
    return g;
  endfunction

  task automatic step(input string tag);
    logic [MP-1:0] g;
    @(negedge clk);
    g       = model_gnt();
    obs_gnt = bus.gnt;
    obs_rv  = bus.r_valid;
    for (int p = 0; p < MP; p++) obs_rd[p] = bus.r_data[p];
    chk({tag, " gnt"}, 32'(obs_gnt), 32'(g));
    chk({tag, " r_valid"}, 32'(obs_rv), rst_n ? 32'(m_rv) : 32'd0);
    for (int p = 0; p < MP; p++)
      chk($sformatf("%s r_data%0d", tag, p), obs_rd[p], rst_n ? m_rd[p] : 32'd0);
    @(posedge clk);
    if (!rst_n) begin
      m_rv = '0;
      for (int p = 0; p < MP; p++) m_rd[p] = '0;
      for (int b = 0; b < NB; b++) m_ptr[b] = 0;
    end else begin
      for (int p = 0; p < MP; p++) begin
        m_rv[p] = g[p];
        m_rd[p] = (g[p] && bus.wen[p]) ? m_mem[word_of(bus.add[p])] : 32'd0;
      end
      for (int p = 0; p < MP; p++) begin
        if (g[p] && !bus.wen[p]) begin
          for (int i = 0; i < 4; i++)
            if (bus.be[p][i]) m_mem[word_of(bus.add[p])][8*i +: 8] = bus.data[p][8*i +: 8];
        end
        if (g[p]) m_ptr[word_of(bus.add[p]) % NB] = (p + 1) % MP;
      end
    end
    #1;
  endtask

  task automatic drive(input int p, input logic rq, input logic [31:0] a,
                       input logic we, input logic [3:0] b, input logic [31:0] d);
    bus.req[p]  = rq;
    bus.add[p]  = a;
    bus.wen[p]  = we;
    bus.be[p]   = b;
    bus.data[p] = d;
  endtask

  task automatic idle();
    bus.req = '0;
    stall   = '0;
  endtask

  function automatic void set_vec(input int i, input logic [3:0] rq, input logic [3:0] st,
                                  input logic [31:0] a0, input logic [31:0] a1,
                                  input logic [31:0] a2, input logic [31:0] a3,
                                  input logic [3:0] eg);
    vecs[i].req     = rq;
    vecs[i].stall   = st;
    vecs[i].add     = {a3, a2, a1, a0};
    vecs[i].exp_gnt = eg;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    set_vec(0, 4'b1111, 4'b0000, 32'h100, 32'h104, 32'h108, 32'h10C, 4'b1111);
    set_vec(1, 4'b0011, 4'b0000, 32'h20,  32'h20,  32'h0,   32'h0,   4'b0001);
    set_vec(2, 4'b1111, 4'b0010, 32'h0,   32'h4,   32'h8,   32'hC,   4'b1101);
    set_vec(3, 4'b1010, 4'b0000, 32'h0,   32'h40,  32'h0,   32'h60,  4'b0010);
    set_vec(4, 4'b0000, 4'b0000, 32'h0,   32'h0,   32'h0,   32'h0,   4'b0000);
    set_vec(5, 4'b1111, 4'b0000, 32'h0,   32'h20,  32'h40,  32'h60,  4'b0001);
    set_vec(6, 4'b1100, 4'b0100, 32'h0,   32'h0,   32'h4,   32'h24,  4'b1000);
    set_vec(7, 4'b0011, 4'b0000, 32'h2000, 32'h0,  32'h0,   32'h0,   4'b0001);
    set_vec(8, 4'b0110, 4'b0000, 32'h0,   32'h1C,  32'h3C,  32'h0,   4'b0010);

    for (int b = 0; b < NB; b++) m_ptr[b] = 0;
    for (int p = 0; p < MP; p++) m_rd[p] = '0;
    bus.req = '0; bus.add = '0; bus.wen = '0; bus.be = '0; bus.data = '0;
    stall = '0;
    rst_n = 1'b0;
    step("reset0");
    step("reset1");
    rst_n = 1'b1;

    // Fill every word so later reads have known contents.
    for (int w = 0; w < WORDS; w += MP) begin
      for (int p = 0; p < MP; p++) drive(p, 1'b1, 32'((w + p) * 4), 1'b0, 4'hF, $urandom);
      step("init");
    end
    idle();

    // Basic write / read and byte enables.
    drive(0, 1'b1, 32'h10, 1'b0, 4'b1111, 32'hDEADBEEF);
    step("wr");
    chk("wr gnt0", 32'(obs_gnt), 32'h1);
    drive(0, 1'b1, 32'h10, 1'b1, 4'b0000, 32'h0);
    step("rd");
    chk("wr resp valid", 32'(obs_rv), 32'h1);
    chk("wr resp data zero", obs_rd[0], 32'h0);
    drive(0, 1'b1, 32'h10, 1'b0, 4'b0101, 32'h11223344);
    step("be_wr");
    chk("rd data", obs_rd[0], 32'hDEADBEEF);
    drive(0, 1'b1, 32'h10, 1'b1, 4'b0000, 32'h0);
    step("be_rd");
    idle();
    step("be_resp");
    chk("be merge", obs_rd[0], 32'hDE22BE44);
    chk("be valid", 32'(obs_rv), 32'h1);

    // Bank conflict after reset (pointer 0).
    rst_n = 1'b0; step("rst_a"); rst_n = 1'b1;
    drive(0, 1'b1, 32'h20, 1'b1, 4'h0, 32'h0);
    drive(1, 1'b1, 32'h20, 1'b1, 4'h0, 32'h0);
    step("conf1");
    chk("conf1 gnt", 32'(obs_gnt), 32'h1);
    step("conf2");
    chk("conf2 gnt", 32'(obs_gnt), 32'h2);
    chk("conf2 valid", 32'(obs_rv), 32'h1);
    idle();
    step("conf3");
    chk("conf3 valid", 32'(obs_rv), 32'h2);
    chk("conf3 data", obs_rd[1], m_mem[8]);

    // Contiguous wide access.
    for (int p = 0; p < MP; p++) drive(p, 1'b1, 32'(32'h100 + 4 * p), 1'b1, 4'h0, 32'h0);
    step("wide");
    chk("wide gnt", 32'(obs_gnt), 32'hF);
    idle();
    step("wide_resp");
    chk("wide valid", 32'(obs_rv), 32'hF);
    for (int p = 0; p < MP; p++) chk($sformatf("wide data%0d", p), obs_rd[p], m_mem[32'h40 + p]);

    // Stall injection and release.
    for (int p = 0; p < MP; p++) drive(p, 1'b1, 32'(4 * p), 1'b1, 4'h0, 32'h0);
    stall = 4'b0010;
    step("stall");
    chk("stall gnt", 32'(obs_gnt), 32'hD);
    bus.req = 4'b0010;
    stall   = 4'b0000;
    step("unstall");
    chk("unstall gnt1", 32'(obs_gnt[1]), 32'h1);
    idle();
    step("unstall_resp");

    // Reset mid-operation: response dropped, pointer cleared, memory kept.
    drive(0, 1'b1, 32'h20, 1'b1, 4'h0, 32'h0);
    step("mid_t");
    chk("mid grant", 32'(obs_gnt), 32'h1);
    idle();
    rst_n = 1'b0;
    step("mid_t1");
    chk("mid t+1 valid", 32'(obs_rv), 32'h0);
    rst_n = 1'b1;
    step("mid_t2");
    chk("mid t+2 valid", 32'(obs_rv), 32'h0);
    drive(0, 1'b1, 32'h40, 1'b1, 4'h0, 32'h0);
    drive(1, 1'b1, 32'h40, 1'b1, 4'h0, 32'h0);
    step("mid_ptr");
    chk("ptr reset gnt", 32'(obs_gnt), 32'h1);
    idle();
    drive(0, 1'b1, 32'h10, 1'b1, 4'h0, 32'h0);
    step("mid_rd");
    idle();
    step("mid_rd_resp");
    chk("retained data", obs_rd[0], 32'hDE22BE44);

    // Single-cycle arbitration table, each vector from a fresh reset.
    for (int i = 0; i < 9; i++) begin
      rst_n = 1'b0; idle(); step("tbl_rst"); rst_n = 1'b1;
      bus.req = vecs[i].req;
      stall   = vecs[i].stall;
      for (int p = 0; p < MP; p++) drive(p, vecs[i].req[p], vecs[i].add[p], 1'b1, 4'h0, 32'h0);
      step("tbl");
      chk($sformatf("tbl%0d gnt", i), 32'(obs_gnt), 32'(vecs[i].exp_gnt));
      idle();
      step("tbl_resp");
      chk($sformatf("tbl%0d valid", i), 32'(obs_rv), 32'(vecs[i].exp_gnt));
    end

    // Randomized traffic over a small window to force conflicts and read-after-write.
    for (int c = 0; c < 2000; c++) begin
      rst_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      for (int p = 0; p < MP; p++) begin
        a = $urandom;
        a[12:2] = 11'($urandom_range(0, 63));
        drive(p, ($urandom_range(0, 9) < 7), a, 1'($urandom), 4'($urandom), $urandom);
      end
      stall = 4'($urandom) & 4'($urandom);
      step("rand");
    end
    rst_n = 1'b1;
    idle();
    step("drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
